instr_fetch: RTL

Instruction fetch stage of the MIPS single-cycle processor. Holds the program counter and an on-chip instruction memory, presents one instruction per cycle, and slices it into the fields consumed directly downstream: `opcode` feeds the main controller, and rs/rt/rd/funct/imm16 feed the register file and ALU control. It accepts a program-load port while idle, applies taken-branch redirects, holds under stall, and stops on a halt word.

---
 rtl/instr_fetch_if.sv | 53 +++++
 rtl/instr_fetch.sv | 130 +++++++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch-stage bus: program load, control, fetched instruction and decode slices
//
// Groups every non-clock, non-reset signal of the fetch stage.
//   master : drives start/load/stall/branch controls, observes fetch outputs
//   slave  : the fetch stage itself
//
// Signals
//   start        IDLE -> RUN request
//   load_en      program-load write strobe (honoured only while idle)
//   load_addr    word address of the program-load write
//   load_data    instruction word to load
//   stall        hold all fetch state this cycle
//   branch_taken redirect fetch relative to the instruction in instr
//   branch_imm   signed word offset of that branch
//   pc           byte address of instr
//   pc_plus4     pc + 4
//   instr        registered instruction word
//   instr_valid  instr is a real instruction (0 = bubble)
//   opcode/rs/rt/rd/funct/imm16  field slices of instr
//   halted       fetch has stopped on a halt word
interface instr_fetch_if #(
  parameter int AW = 8
);
  logic        start;
  logic        load_en;
  logic [AW-1:0] load_addr;
  logic [31:0] load_data;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_imm;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic        instr_valid;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic        halted;

  modport master (
    output start, load_en, load_addr, load_data, stall, branch_taken, branch_imm,
    input  pc, pc_plus4, instr, instr_valid, opcode, rs, rt, rd, funct, imm16, halted
  );

  modport slave (
    input  start, load_en, load_addr, load_data, stall, branch_taken, branch_imm,
    output pc, pc_plus4, instr, instr_valid, opcode, rs, rt, rd, funct, imm16, halted
  );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-cycle MIPS instruction fetch stage with on-chip instruction memory
//
// Holds the program counter and an IMEM_DEPTH x 32 instruction memory. While
// idle the memory is written through the load port; after start, one word per
// cycle is fetched into instr and sliced into decode fields. Taken branches
// redirect fetch with a single bubble, stall freezes fetch state, and a word
// whose opcode equals HALT_OPCODE stops fetch until reset.
//
// Ports
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset (memory contents are kept)
//   bus  : instr_fetch_if.slave - controls in, instruction/decode/status out
module instr_fetch #(
  parameter int          IMEM_DEPTH  = 256,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.slave  bus
);

  localparam int AW = $clog2(IMEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;

  logic [31:0] imem_q [IMEM_DEPTH];
  logic [31:0] rd_word;
  logic [31:0] branch_off;
  logic        mem_we;

  // Word index drops the byte offset; upper bits beyond the memory wrap.
  assign rd_word = imem_q[fetch_pc_q[AW+1:2]];

  // Sign-extended word offset converted to a byte offset.
  assign branch_off = {{14{bus.branch_imm[15]}}, bus.branch_imm, 2'b00};

  // A start in the same cycle as a load wins; the load is dropped.
  assign mem_we = !rst && (state_q == S_IDLE) && bus.load_en && !bus.start;

  // Program memory has no reset so a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      imem_q[bus.load_addr] <= bus.load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= 32'd0;
      pc_q       <= 32'd0;
      instr_q    <= 32'd0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (bus.branch_taken) begin
          // The branch is the instruction in instr, so the target is
          // relative to pc, not to fetch_pc (which is already one ahead).
          fetch_pc_d = pc_q + 32'd4 + branch_off;
          instr_d    = 32'd0;
          valid_d    = 1'b0;
        end else if (!bus.stall) begin
          instr_d = rd_word;
          pc_d    = fetch_pc_q;
          valid_d = 1'b1;
          if (rd_word[31:26] == HALT_OPCODE) begin
            // Present the halt word once, then stop without advancing.
            state_d = S_HALT;
          end else begin
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end
      end

      S_HALT: begin
        valid_d = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_q + 32'd4;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.halted      = (state_q == S_HALT);

  assign bus.opcode = instr_q[31:26];
  assign bus.rs     = instr_q[25:21];
  assign bus.rt     = instr_q[20:16];
  assign bus.rd     = instr_q[15:11];
  assign bus.funct  = instr_q[5:0];
  assign bus.imm16  = instr_q[15:0];

endmodule
